// File: rtl/ervp_cache_access_frontend_pkg.sv
// Shared widths and record layout for the cache access front-end.
// Request record packs {addr, write, wstrb, wdata} from MSB to LSB; response record packs {write, rdata}.
package ervp_cache_frontend_pkg;

  typedef enum logic {
    FE_READ  = 1'b0,
    FE_WRITE = 1'b1
  } fe_access_e;

  function automatic int unsigned BW_WSTRB(input int unsigned bw_access);
    return bw_access / 8;
  endfunction

  function automatic int unsigned BW_CNT(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned BW_REQ(input int unsigned bw_addr, input int unsigned bw_access);
    return bw_addr + 1 + BW_WSTRB(bw_access) + bw_access;
  endfunction

  function automatic int unsigned BW_RESP(input int unsigned bw_access);
    return 1 + bw_access;
  endfunction

  // LSB offsets of each field inside the request record.
  function automatic int unsigned OFS_WSTRB(input int unsigned bw_access);
    return bw_access;
  endfunction

  function automatic int unsigned OFS_WRITE(input int unsigned bw_access);
    return bw_access + BW_WSTRB(bw_access);
  endfunction

  function automatic int unsigned OFS_ADDR(input int unsigned bw_access);
    return OFS_WRITE(bw_access) + 1;
  endfunction

endpackage

// File: rtl/ervp_cache_access_frontend_fifo.sv
// Synchronous FIFO with registered storage, flush and occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ervp_cache_fe_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push && !flush_i) begin
        mem_q[wptr_q] <= wdata_i;
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ervp_cache_access_frontend.sv
// Core-side front-end of the cache access port: in-order request issue bounded by
// credits (outstanding + buffered responses), with flush that silently drains in-flight responses.
module ervp_cache_access_frontend
  import ervp_cache_frontend_pkg::*;
#(
  parameter int unsigned BW_ADDR         = 32,
  parameter int unsigned BW_ACCESS       = 32,
  parameter int unsigned REQ_DEPTH       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  output logic                           busy,
  output logic                           error,
  output logic                           core_rqready,
  input  logic                           core_rqvalid,
  input  logic [BW_ADDR-1:0]             core_rqaddr,
  input  logic                           core_rqwrite,
  input  logic [BW_WSTRB(BW_ACCESS)-1:0] core_rqwstrb,
  input  logic [BW_ACCESS-1:0]           core_rqwdata,
  input  logic                           core_ryready,
  output logic                           core_ryvalid,
  output logic                           core_rywrite,
  output logic [BW_ACCESS-1:0]           core_ryrdata,
  input  logic                           access_cqready,
  output logic                           access_cqvalid,
  output logic [BW_ADDR-1:0]             access_cqaddr,
  output logic                           access_cqwrite,
  output logic [BW_WSTRB(BW_ACCESS)-1:0] access_cqwstrb,
  output logic [BW_ACCESS-1:0]           access_cqwdata,
  input  logic                           access_cyvalid,
  input  logic [BW_ACCESS-1:0]           access_cyrdata
);

  localparam int unsigned BW_STRB = BW_WSTRB(BW_ACCESS);
  localparam int unsigned CW      = BW_CNT(MAX_OUTSTANDING);
  localparam int unsigned RQCW    = BW_CNT(REQ_DEPTH);
  localparam int unsigned RQW     = BW_REQ(BW_ADDR, BW_ACCESS);
  localparam int unsigned RYW     = BW_RESP(BW_ACCESS);
  localparam int unsigned O_STRB  = OFS_WSTRB(BW_ACCESS);
  localparam int unsigned O_WRITE = OFS_WRITE(BW_ACCESS);
  localparam int unsigned O_ADDR  = OFS_ADDR(BW_ACCESS);

  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        discard_q, discard_d;
  logic                 error_q, error_d;

  logic [RQW-1:0]       req_wdata, req_rdata;
  logic [RQCW-1:0]      req_cnt;
  logic                 req_push, req_empty, req_full;
  logic                 infl_wdata, infl_rdata;
  logic [CW-1:0]        infl_cnt;
  logic [RYW-1:0]       resp_wdata, resp_rdata;
  logic [CW-1:0]        resp_cnt;
  logic                 resp_push, resp_pop;
  logic [BW_ACCESS-1:0] resp_data;
  logic [CW:0]          credit_used;
  logic                 credit_ok, issue, cy_accept;
  fe_access_e           resp_kind;

  assign req_empty    = (req_cnt == '0);
  assign req_full     = (req_cnt == RQCW'(REQ_DEPTH));
  assign core_rqready = !req_full && !clear;
  assign req_push     = core_rqvalid && core_rqready;
  assign req_wdata    = {core_rqaddr, core_rqwrite, core_rqwstrb, core_rqwdata};

  ervp_cache_fe_fifo #(
    .WIDTH (RQW),
    .DEPTH (REQ_DEPTH)
  ) u_reqfifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (clear),
    .push_i  (req_push),
    .wdata_i (req_wdata),
    .pop_i   (issue),
    .rdata_o (req_rdata),
    .count_o (req_cnt)
  );

  // Credits count responses still buffered, so the response FIFO can never overflow.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, resp_cnt};
  assign credit_ok      = credit_used < (CW + 1)'(MAX_OUTSTANDING);
  assign access_cqvalid = !req_empty && credit_ok && !clear;
  assign issue          = access_cqvalid && access_cqready;

  assign access_cqaddr  = req_rdata[O_ADDR +: BW_ADDR];
  assign access_cqwrite = req_rdata[O_WRITE];
  assign access_cqwstrb = req_rdata[O_STRB +: BW_STRB];
  assign access_cqwdata = req_rdata[BW_ACCESS-1:0];

  assign infl_wdata = access_cqwrite;
  assign cy_accept  = access_cyvalid && (outstanding_q != '0);

  // Never flushed: responses to requests issued before a clear still arrive and must be matched.
  ervp_cache_fe_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (issue),
    .wdata_i (infl_wdata),
    .pop_i   (cy_accept),
    .rdata_o (infl_rdata),
    .count_o (infl_cnt)
  );

  assign resp_kind  = fe_access_e'(infl_rdata);
  assign resp_data  = (resp_kind == FE_WRITE) ? '0 : access_cyrdata;
  assign resp_wdata = {infl_rdata, resp_data};
  assign resp_push  = cy_accept && (discard_q == '0) && !clear;
  assign resp_pop   = core_ryvalid && core_ryready;

  ervp_cache_fe_fifo #(
    .WIDTH (RYW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_respfifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (clear),
    .push_i  (resp_push),
    .wdata_i (resp_wdata),
    .pop_i   (resp_pop),
    .rdata_o (resp_rdata),
    .count_o (resp_cnt)
  );

  assign core_ryvalid = (resp_cnt != '0);
  assign core_rywrite = resp_rdata[BW_ACCESS];
  assign core_ryrdata = resp_rdata[BW_ACCESS-1:0];

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !cy_accept) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!issue && cy_accept) begin
      outstanding_d = outstanding_q - CW'(1);
    end
    discard_d = discard_q;
    // A response arriving in the clear cycle is consumed there, so it is not counted for discard.
    if (clear) begin
      discard_d = cy_accept ? outstanding_q - CW'(1) : outstanding_q;
    end else if (cy_accept && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
    error_d = error_q || (access_cyvalid && (outstanding_q == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      discard_q     <= '0;
      error_q       <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      error_q       <= error_d;
    end
  end

  assign error = error_q;
  assign busy  = (req_cnt != '0) || (infl_cnt != '0) || (resp_cnt != '0)
              || (outstanding_q != '0) || (discard_q != '0);

endmodule

// File: tb/tb_ervp_cache_access_frontend.sv
// Randomized and directed bench for ervp_cache_access_frontend against a queue-based reference model.
module tb_ervp_cache_access_frontend;

  localparam int unsigned BW_ADDR   = 32;
  localparam int unsigned BW_ACCESS = 32;
  localparam int unsigned REQ_DEPTH = 2;
  localparam int unsigned MAX_OUT   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        busy, error, core_rqready;
  logic        core_rqvalid = 1'b0;
  logic [31:0] core_rqaddr = '0;
  logic        core_rqwrite = 1'b0;
  logic [3:0]  core_rqwstrb = '0;
  logic [31:0] core_rqwdata = '0;
  logic        core_ryready = 1'b0;
  logic        core_ryvalid, core_rywrite;
  logic [31:0] core_ryrdata;
  logic        access_cqready = 1'b0;
  logic        access_cqvalid, access_cqwrite;
  logic [31:0] access_cqaddr, access_cqwdata;
  logic [3:0]  access_cqwstrb;
  logic        access_cyvalid = 1'b0;
  logic [31:0] access_cyrdata = '0;

  ervp_cache_access_frontend #(
    .BW_ADDR         (BW_ADDR),
    .BW_ACCESS       (BW_ACCESS),
    .REQ_DEPTH       (REQ_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .busy           (busy),
    .error          (error),
    .core_rqready   (core_rqready),
    .core_rqvalid   (core_rqvalid),
    .core_rqaddr    (core_rqaddr),
    .core_rqwrite   (core_rqwrite),
    .core_rqwstrb   (core_rqwstrb),
    .core_rqwdata   (core_rqwdata),
    .core_ryready   (core_ryready),
    .core_ryvalid   (core_ryvalid),
    .core_rywrite   (core_rywrite),
    .core_ryrdata   (core_ryrdata),
    .access_cqready (access_cqready),
    .access_cqvalid (access_cqvalid),
    .access_cqaddr  (access_cqaddr),
    .access_cqwrite (access_cqwrite),
    .access_cqwstrb (access_cqwstrb),
    .access_cqwdata (access_cqwdata),
    .access_cyvalid (access_cyvalid),
    .access_cyrdata (access_cyrdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit [31:0] addr; bit write; bit [3:0] strb; bit [31:0] data; } req_t;
  typedef struct { bit write; bit [31:0] data; } rsp_t;

  // Reference model state
  req_t m_req[$];
  bit   m_infl[$];
  rsp_t m_rsp[$];
  int   m_disc = 0;
  bit   m_err = 1'b0;

  // Bench-side cache and core stimulus
  req_t stim_q[$];
  rsp_t cpend[$];
  bit [31:0] cmem[bit [31:0]];

  int rq_prob = 100, cq_prob = 100, cy_prob = 0, ry_prob = 100;
  int cq_budget = 1000000;
  bit clear_req = 0, spur_req = 0, force_cy = 0, cy_on_issue = 0;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int issue_cnt = 0, ry_cnt = 0, same_cnt = 0, last_cy_cyc = 0, last_issue_cyc = 0;
  rsp_t ry_log[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit [31:0] mem_rd(bit [31:0] a);
    return cmem.exists(a) ? cmem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic void push_req(bit [31:0] a, bit w, bit [3:0] s, bit [31:0] d);
    req_t r;
    r.addr = a; r.write = w; r.strb = s; r.data = d;
    stim_q.push_back(r);
  endfunction

  task automatic cycle();
    bit exp_rqr, exp_cqv, exp_ryv, exp_busy, cyacc, iss, rqhs, ryhs, w;
    bit [31:0] v;
    req_t r;
    rsp_t p;
    @(negedge clk);
    cyc++;
    clear = clear_req;
    clear_req = 0;
    exp_rqr = (m_req.size() < REQ_DEPTH) && !clear;
    exp_cqv = (m_req.size() > 0) && ((m_infl.size() + m_rsp.size()) < MAX_OUT) && !clear;
    exp_ryv = m_rsp.size() > 0;
    exp_busy = (m_req.size() > 0) || (m_infl.size() > 0) || (m_rsp.size() > 0) || (m_disc > 0);

    core_rqvalid = (stim_q.size() > 0) && ($urandom % 100 < rq_prob);
    if (core_rqvalid) begin
      core_rqaddr = stim_q[0].addr; core_rqwrite = stim_q[0].write;
      core_rqwstrb = stim_q[0].strb; core_rqwdata = stim_q[0].data;
    end else begin
      core_rqaddr = $urandom; core_rqwrite = 1'($urandom);
      core_rqwstrb = 4'($urandom); core_rqwdata = $urandom;
    end
    access_cqready = (cq_budget > 0) && ($urandom % 100 < cq_prob);
    core_ryready = ($urandom % 100 < ry_prob);
    access_cyvalid = 1'b0;
    access_cyrdata = $urandom;
    if (spur_req) begin
      access_cyvalid = 1'b1;
      spur_req = 0;
    end else if (cpend.size() > 0) begin
      if (cy_on_issue && exp_cqv && access_cqready) begin
        access_cyvalid = 1'b1; cy_on_issue = 0; same_cnt++;
      end else if (force_cy || ($urandom % 100 < cy_prob)) begin
        access_cyvalid = 1'b1; force_cy = 0;
      end
      if (access_cyvalid && !cpend[0].write) access_cyrdata = cpend[0].data;
    end

    #1;
    chk("rqready", core_rqready, exp_rqr);
    chk("cqvalid", access_cqvalid, exp_cqv);
    chk("ryvalid", core_ryvalid, exp_ryv);
    chk("busy", busy, exp_busy);
    chk("error", error, m_err);
    if (exp_cqv) begin
      chk("cqaddr", access_cqaddr, m_req[0].addr);
      chk("cqwrite", access_cqwrite, m_req[0].write);
      chk("cqwstrb", access_cqwstrb, m_req[0].strb);
      chk("cqwdata", access_cqwdata, m_req[0].data);
    end
    if (exp_ryv) begin
      chk("rywrite", core_rywrite, m_rsp[0].write);
      chk("ryrdata", core_ryrdata, m_rsp[0].data);
    end

    if (access_cqvalid && access_cqready) begin issue_cnt++; last_issue_cyc = cyc; end
    if (core_ryvalid && core_ryready) begin
      p.write = core_rywrite; p.data = core_ryrdata; ry_log.push_back(p); ry_cnt++;
    end
    if (access_cyvalid) last_cy_cyc = cyc;

    // Model and bench-cache update for the coming clock edge
    iss = exp_cqv && access_cqready;
    rqhs = core_rqvalid && exp_rqr;
    ryhs = exp_ryv && core_ryready;
    cyacc = access_cyvalid && (m_infl.size() > 0);
    if (access_cyvalid && !cyacc) m_err = 1'b1;
    if (access_cyvalid && cpend.size() > 0) void'(cpend.pop_front());
    w = 1'b0;
    if (cyacc) w = m_infl.pop_front();
    if (clear) begin
      m_req.delete();
      m_rsp.delete();
      m_disc = m_infl.size();
    end else begin
      if (ryhs) void'(m_rsp.pop_front());
      if (cyacc) begin
        if (m_disc > 0) m_disc--;
        else begin p.write = w; p.data = w ? 32'h0 : access_cyrdata; m_rsp.push_back(p); end
      end
      if (iss) begin
        r = m_req.pop_front();
        m_infl.push_back(r.write);
        p.write = r.write; p.data = r.write ? 32'h0 : mem_rd(r.addr);
        cpend.push_back(p);
        if (r.write) begin
          v = mem_rd(r.addr);
          for (int b = 0; b < 4; b++) if (r.strb[b]) v[8*b +: 8] = r.data[8*b +: 8];
          cmem[r.addr] = v;
        end
        cq_budget--;
      end
      if (rqhs) m_req.push_back(stim_q.pop_front());
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic async_reset();
    @(negedge clk);
    core_rqvalid = 0; access_cyvalid = 0; clear = 0; access_cqready = 0; core_ryready = 0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_cqvalid", access_cqvalid, 1'b0);
    chk("arst_ryvalid", core_ryvalid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_error", error, 1'b0);
    chk("arst_rqready", core_rqready, 1'b1);
    m_req.delete(); m_infl.delete(); m_rsp.delete(); m_disc = 0; m_err = 0;
    cpend.delete(); stim_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int b0, i0, r0;
    #1 rst = 1'b1;
    #1;
    chk("rst_rqready", core_rqready, 1'b1);
    chk("rst_cqvalid", access_cqvalid, 1'b0);
    chk("rst_ryvalid", core_ryvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_cqaddr", access_cqaddr, 32'h0);
    chk("rst_cqwdata", access_cqwdata, 32'h0);
    chk("rst_ryrdata", core_ryrdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Read burst with stalled responses
    for (int i = 0; i < 6; i++) push_req(32'h1000 + 4 * i, 1'b0, 4'h0, 32'h0);
    cy_prob = 0; b0 = ry_cnt;
    run(20);
    chk("burst_accepted", issue_cnt, 4);
    force_cy = 1;
    cycle();
    for (int i = 0; i < 10 && issue_cnt < 5; i++) cycle();
    // The credit returns once the response has also left the response buffer.
    chk("burst_5th_delay", last_issue_cyc - last_cy_cyc, 2);
    cy_prob = 100;
    run(30);
    chk("burst_returned", ry_cnt - b0, 6);
    chk("burst_first_data", ry_log[b0].data, 32'hA5A5_1000);
    chk("burst_last_data", ry_log[b0 + 5].data, 32'hA5A5_1014);

    // Core backpressure
    b0 = ry_cnt; i0 = issue_cnt;
    for (int i = 0; i < 5; i++) push_req(32'h2000 + 4 * i, 1'b0, 4'h0, 32'h0);
    ry_prob = 0; cy_prob = 100;
    run(20);
    chk("bp_issued", issue_cnt - i0, 4);
    chk("bp_ryvalid", core_ryvalid, 1'b1);
    chk("bp_cqvalid", access_cqvalid, 1'b0);
    ry_prob = 100;
    run(20);
    chk("bp_returned", ry_cnt - b0, 5);
    chk("bp_first", ry_log[b0].data, 32'hA5A5_2000);
    chk("bp_last", ry_log[b0 + 4].data, 32'hA5A5_2010);

    // Mixed write then read to the same address
    b0 = ry_cnt;
    push_req(32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    push_req(32'h100, 1'b0, 4'h0, 32'h0);
    run(20);
    chk("mix_count", ry_cnt - b0, 2);
    chk("mix_w_write", ry_log[b0].write, 1'b1);
    chk("mix_w_data", ry_log[b0].data, 32'h0);
    chk("mix_r_write", ry_log[b0 + 1].write, 1'b0);
    chk("mix_r_data", ry_log[b0 + 1].data, 32'hDEAD_BEEF);

    // Clear with 3 outstanding and 2 queued
    cy_prob = 0; cq_budget = 3; i0 = issue_cnt;
    for (int i = 0; i < 5; i++) push_req(32'h3000 + 4 * i, 1'b0, 4'h0, 32'h0);
    run(12);
    chk("clr_issued", issue_cnt - i0, 3);
    clear_req = 1; cq_budget = 1000000;
    run(6);
    chk("clr_no_issue", issue_cnt - i0, 3);
    chk("clr_busy", busy, 1'b1);
    b0 = ry_cnt; cy_prob = 100;
    run(8);
    chk("clr_no_resp", ry_cnt - b0, 0);
    chk("clr_idle", busy, 1'b0);
    push_req(32'h4000, 1'b0, 4'h0, 32'h0);
    run(10);
    chk("clr_after", ry_cnt - b0, 1);
    chk("clr_after_data", ry_log[b0].data, 32'hA5A5_4000);

    // Same-cycle issue and response at outstanding = MAX-1
    cy_prob = 0; b0 = ry_cnt;
    for (int i = 0; i < 3; i++) push_req(32'h5000 + 4 * i, 1'b0, 4'h0, 32'h0);
    run(10);
    cy_on_issue = 1;
    push_req(32'h500C, 1'b0, 4'h0, 32'h0);
    run(10);
    chk("same_cycle_hit", same_cnt, 1);
    cy_prob = 100;
    run(15);
    chk("same_count", ry_cnt - b0, 4);
    for (int i = 0; i < 4; i++) chk("same_order", ry_log[b0 + i].data, 32'hA5A5_5000 + 4 * i);

    // Randomized traffic with occasional clears
    rq_prob = 60; cq_prob = 70; cy_prob = 50; ry_prob = 60;
    for (int n = 0; n < 2500; n++) begin
      if (stim_q.size() < 2)
        push_req(32'h8000 + 4 * ($urandom % 8), 1'($urandom), 4'($urandom), $urandom);
      if ($urandom % 100 == 0) clear_req = 1;
      cycle();
    end
    stim_q.delete();
    rq_prob = 100; cq_prob = 100; cy_prob = 100; ry_prob = 100;
    run(30);
    chk("drain_idle", busy, 1'b0);

    // Spurious response and mid-burst asynchronous reset
    spur_req = 1;
    run(2);
    chk("spur_error", error, 1'b1);
    r0 = ry_cnt;
    push_req(32'h6000, 1'b0, 4'h0, 32'h0);
    run(10);
    chk("spur_sticky", error, 1'b1);
    chk("spur_then_ok", ry_cnt - r0, 1);
    cy_prob = 0;
    for (int i = 0; i < 4; i++) push_req(32'h7000 + 4 * i, 1'b0, 4'h0, 32'h0);
    run(4);
    async_reset();
    run(3);
    chk("post_rst_error", error, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
